// File: rtl/dmem_port_arbiter_if.sv
// Shared data-RAM port bundle: CPU requester, debug/loader requester and the RAM side.
// The arbiter connects through the slave modport; the master modport is the client/RAM environment.
interface dmem_port_arbiter_if;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;

  logic [31:0] dbg_address;
  logic        dbg_read;
  logic        dbg_write;
  logic [31:0] dbg_writedata;
  logic        dbg_waitrequest;
  logic [31:0] dbg_readdata;
  logic        dbg_rvalid;

  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_readdata;

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata,
    output cpu_readdata, cpu_waitrequest,
    input  dbg_address, dbg_read, dbg_write, dbg_writedata,
    output dbg_waitrequest, dbg_readdata, dbg_rvalid,
    output mem_address, mem_writedata, mem_read, mem_write,
    input  mem_readdata
  );

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata,
    input  cpu_readdata, cpu_waitrequest,
    output dbg_address, dbg_read, dbg_write, dbg_writedata,
    input  dbg_waitrequest, dbg_readdata, dbg_rvalid,
    input  mem_address, mem_writedata, mem_read, mem_write,
    output mem_readdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for a single-cycle data RAM: CPU normally wins, a starved debug port
// gets priority after MAX_WAIT (legal 1..15) consecutive denied cycles.
//
// state   | meaning
// PRI_CPU | CPU wins a collision; debug denials are counted in starve_cnt
// PRI_DBG | debug wins a collision; left after any debug grant or idle debug cycle
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_DBG = 1'b1
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;

  logic cpu_req;
  logic dbg_req;
  logic cpu_grant;
  logic dbg_grant;
  logic dbg_rd_grant;

  assign cpu_req = bus.cpu_read | bus.cpu_write;
  assign dbg_req = bus.dbg_read | bus.dbg_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PRI_CPU;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (dbg_grant || !dbg_req) begin
      starve_nxt = 4'd0;
    end else if (starve_cnt >= MAX_WAIT_C) begin
      starve_nxt = MAX_WAIT_C;
    end else begin
      starve_nxt = starve_cnt + 4'd1;
    end

    state_nxt = state;
    case (state)
      PRI_CPU: if (starve_nxt == MAX_WAIT_C) state_nxt = PRI_DBG;
      PRI_DBG: if (dbg_grant || !dbg_req) state_nxt = PRI_CPU;
      default: state_nxt = PRI_CPU;
    endcase
  end

  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    case (state)
      PRI_DBG: begin
        dbg_grant = dbg_req;
        cpu_grant = cpu_req & ~dbg_req;
      end
      default: begin
        cpu_grant = cpu_req;
        dbg_grant = dbg_req & ~cpu_req;
      end
    endcase

    // A simultaneous read+write strobe is issued as a write only.
    bus.mem_address   = 32'd0;
    bus.mem_writedata = 32'd0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    if (cpu_grant) begin
      bus.mem_address   = bus.cpu_address;
      bus.mem_writedata = bus.cpu_writedata;
      bus.mem_read      = bus.cpu_read & ~bus.cpu_write;
      bus.mem_write     = bus.cpu_write;
    end else if (dbg_grant) begin
      bus.mem_address   = bus.dbg_address;
      bus.mem_writedata = bus.dbg_writedata;
      bus.mem_read      = bus.dbg_read & ~bus.dbg_write;
      bus.mem_write     = bus.dbg_write;
    end

    bus.cpu_waitrequest = cpu_req & ~cpu_grant;
    bus.dbg_waitrequest = dbg_req & ~dbg_grant;
    bus.cpu_readdata    = (cpu_grant && bus.cpu_read && !bus.cpu_write) ? bus.mem_readdata : 32'd0;
  end

  assign dbg_rd_grant = dbg_grant & bus.dbg_read & ~bus.dbg_write;

  // Debug read data is registered so the loader sees it one cycle after its grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dbg_readdata <= 32'd0;
      bus.dbg_rvalid   <= 1'b0;
    end else begin
      bus.dbg_rvalid <= dbg_rd_grant;
      if (dbg_rd_grant) bus.dbg_readdata <= bus.mem_readdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed RAM model on the mem side.
module tb_dmem_port_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(.MAX_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0]  ram [0:255];
  logic [255:0] written = '0;

  function automatic logic [31:0] ram_word(input logic [7:0] idx);
    if (written[idx]) return ram[idx];
    case (idx)
      8'h40:   return 32'h7856_3412;
      8'h41:   return 32'hCAFE_F00D;
      default: return {24'hA5A5A5, idx};
    endcase
  endfunction

  assign bus.mem_readdata = ram_word(bus.mem_address[9:2]);

  always @(posedge clk) begin
    if (bus.mem_write) begin
      ram[bus.mem_address[9:2]]     <= bus.mem_writedata;
      written[bus.mem_address[9:2]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu_set(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_read      = rd;
    bus.cpu_write     = wr;
    bus.cpu_address   = addr;
    bus.cpu_writedata = data;
  endtask

  task automatic dbg_set(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.dbg_read      = rd;
    bus.dbg_write     = wr;
    bus.dbg_address   = addr;
    bus.dbg_writedata = data;
  endtask

  task automatic expect_grant(input string tag, input logic dbg_turn);
    check({tag, "_cpu_wait"}, bus.cpu_waitrequest, dbg_turn);
    check({tag, "_dbg_wait"}, bus.dbg_waitrequest, !dbg_turn);
    check({tag, "_addr"}, bus.mem_address, dbg_turn ? 32'h104 : 32'h100);
  endtask

  initial begin
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", dut.state, 32'd0);
    check("rst_starve", dut.starve_cnt, 32'd0);
    check("rst_rvalid", bus.dbg_rvalid, 32'd0);
    check("rst_rdata", bus.dbg_readdata, 32'd0);
    check("rst_mem_read", bus.mem_read, 32'd0);

    @(negedge clk) reset = 1'b1;
    cpu_set(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    check("cpu_rd_addr", bus.mem_address, 32'h100);
    check("cpu_rd_strobe", bus.mem_read, 32'd1);
    check("cpu_rd_data", bus.cpu_readdata, 32'h7856_3412);
    check("cpu_rd_wait", bus.cpu_waitrequest, 32'd0);

    @(negedge clk);
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_set(1'b1, 1'b0, 32'h104, 32'h0);
    #1;
    check("dbg_rd_wait", bus.dbg_waitrequest, 32'd0);
    check("dbg_rd_addr", bus.mem_address, 32'h104);
    check("cpu_idle_wait", bus.cpu_waitrequest, 32'd0);
    check("cpu_idle_rdata", bus.cpu_readdata, 32'd0);

    @(negedge clk);
    dbg_set(1'b0, 1'b1, 32'h10C, 32'h1111_2222);
    #1;
    check("dbg_rvalid_1", bus.dbg_rvalid, 32'd1);
    check("dbg_rdata_1", bus.dbg_readdata, 32'hCAFE_F00D);
    check("dbg_wr_strobe", bus.mem_write, 32'd1);

    @(negedge clk);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("dbg_rvalid_0", bus.dbg_rvalid, 32'd0);
    check("dbg_rdata_held", bus.dbg_readdata, 32'hCAFE_F00D);
    check("dbg_wr_ram", ram_word(8'h43), 32'h1111_2222);

    @(negedge clk);
    cpu_set(1'b1, 1'b1, 32'h108, 32'hDEAD_BEEF);
    #1;
    check("rw_mem_write", bus.mem_write, 32'd1);
    check("rw_mem_read", bus.mem_read, 32'd0);
    check("rw_wdata", bus.mem_writedata, 32'hDEAD_BEEF);
    check("rw_cpu_rdata", bus.cpu_readdata, 32'd0);

    @(negedge clk);
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rw_ram", ram_word(8'h42), 32'hDEAD_BEEF);

    // Continuous contention: CPU,CPU,CPU,DBG repeating.
    @(negedge clk);
    cpu_set(1'b1, 1'b0, 32'h100, 32'h0);
    dbg_set(1'b1, 1'b0, 32'h104, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      expect_grant($sformatf("both_c%0d", i), (i % 4) == 3);
      @(negedge clk);
    end
    #1;
    check("both_rvalid", bus.dbg_rvalid, 32'd1);
    check("both_rdata", bus.dbg_readdata, 32'hCAFE_F00D);

    // Two denials, then debug goes idle: the count must restart from zero.
    @(negedge clk);
    #1;
    expect_grant("pre_idle", 1'b0);
    @(negedge clk);
    dbg_set(1'b0, 1'b0, 32'h104, 32'h0);
    #1;
    check("dbg_idle_wait", bus.dbg_waitrequest, 32'd0);
    @(negedge clk);
    dbg_set(1'b1, 1'b0, 32'h104, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_grant($sformatf("restart_c%0d", i), 1'b0);
      @(negedge clk);
    end
    #1;
    check("esc_state", dut.state, 32'd1);
    check("esc_starve", dut.starve_cnt, 32'd3);

    // Reset in PRI_DBG with both ports still requesting.
    reset = 1'b0;
    #1;
    check("midrst_state", dut.state, 32'd0);
    check("midrst_starve", dut.starve_cnt, 32'd0);
    check("midrst_rvalid", bus.dbg_rvalid, 32'd0);
    check("midrst_rdata", bus.dbg_readdata, 32'd0);
    expect_grant("midrst", 1'b0);

    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      expect_grant($sformatf("post_rst_c%0d", i), i == 3);
      @(negedge clk);
    end

    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
